// File: rtl/pattern_repeat_checker.sv
// Checker for the repeated-count pattern VAL_MIN..VAL_MAX, each value REP times.
// Hunts for alignment, locks after LOCK_N good samples, and reports mismatches and frames.
module pattern_repeat_checker #(
    parameter int W        = 4,
    parameter int VAL_MIN  = 1,
    parameter int VAL_MAX  = 9,
    parameter int REP      = 2,
    parameter int LOCK_N   = 4,
    parameter int UNLOCK_N = 3,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [W-1:0]     in_data,
    input  logic             clr_stats,
    output logic             locked,
    output logic             err,
    output logic             frame_done,
    output logic [W-1:0]     exp_data,
    output logic [CNT_W-1:0] err_count
);

    localparam int RW = (REP > 1) ? $clog2(REP) : 1;
    localparam int SW = $clog2(LOCK_N + 1);
    localparam int MW = $clog2(UNLOCK_N + 1);

    typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

    state_t           state_q;
    logic [W-1:0]     val_q;
    logic [RW-1:0]    rep_q;
    logic [W-1:0]     prev_q;
    logic [SW-1:0]    sync_q;
    logic [MW-1:0]    miss_q;
    logic             locked_q;
    logic             err_q;
    logic             fd_q;
    logic [CNT_W-1:0] cnt_q;

    logic             match;
    logic             last_rep;
    logic             at_end;
    logic             align;
    logic [W-1:0]     adv_val;
    logic [RW-1:0]    adv_rep;
    logic [CNT_W-1:0] cnt_inc;

    // In HUNT the position is always (VAL_MIN, 0), so the same advance logic
    // also yields the position just past an aligning sample.
    always_comb begin
        match    = (in_data == val_q);
        last_rep = (rep_q == RW'(REP - 1));
        at_end   = last_rep && (val_q == W'(VAL_MAX));
        align    = (in_data == W'(VAL_MIN)) && (prev_q != W'(VAL_MIN));
        adv_val  = val_q;
        adv_rep  = rep_q + RW'(1);
        if (last_rep) begin
            adv_rep = '0;
            adv_val = at_end ? W'(VAL_MIN) : val_q + W'(1);
        end
        cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= HUNT;
            val_q    <= W'(VAL_MIN);
            rep_q    <= '0;
            prev_q   <= W'(VAL_MAX);
            sync_q   <= '0;
            miss_q   <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            fd_q     <= 1'b0;
            cnt_q    <= '0;
        end else begin
            err_q <= 1'b0;
            fd_q  <= 1'b0;
            if (in_valid) begin
                prev_q <= in_data;
                unique case (state_q)
                    HUNT: begin
                        if (align) begin
                            val_q  <= adv_val;
                            rep_q  <= adv_rep;
                            sync_q <= SW'(1);
                            if (LOCK_N == 1) begin
                                state_q  <= LOCKED;
                                locked_q <= 1'b1;
                            end else begin
                                state_q <= SYNC;
                            end
                        end
                    end
                    SYNC: begin
                        if (match) begin
                            val_q  <= adv_val;
                            rep_q  <= adv_rep;
                            sync_q <= sync_q + SW'(1);
                            if (sync_q == SW'(LOCK_N - 1)) begin
                                state_q  <= LOCKED;
                                locked_q <= 1'b1;
                            end
                        end else begin
                            state_q <= HUNT;
                            val_q   <= W'(VAL_MIN);
                            rep_q   <= '0;
                            sync_q  <= '0;
                        end
                    end
                    LOCKED: begin
                        fd_q  <= at_end;
                        val_q <= adv_val;
                        rep_q <= adv_rep;
                        if (match) begin
                            miss_q <= '0;
                        end else begin
                            err_q <= 1'b1;
                            cnt_q <= cnt_inc;
                            if (miss_q == MW'(UNLOCK_N - 1)) begin
                                state_q  <= HUNT;
                                locked_q <= 1'b0;
                                val_q    <= W'(VAL_MIN);
                                rep_q    <= '0;
                                miss_q   <= '0;
                                sync_q   <= '0;
                            end else begin
                                miss_q <= miss_q + MW'(1);
                            end
                        end
                    end
                    default: state_q <= HUNT;
                endcase
            end
            if (clr_stats) begin
                cnt_q <= '0;
            end
        end
    end

    assign locked     = locked_q;
    assign err        = err_q;
    assign frame_done = fd_q;
    assign exp_data   = val_q;
    assign err_count  = cnt_q;

endmodule

// File: tb/tb_pattern_repeat_checker.sv
// Bench for pattern_repeat_checker: positional reference model feeding a scoreboard,
// a hand-computed vector table for lock acquisition, and directed corner sequences.
module tb_pattern_repeat_checker;

    localparam int VMIN     = 1;
    localparam int VMAX     = 9;
    localparam int REP      = 2;
    localparam int LOCK_N   = 4;
    localparam int UNLOCK_N = 3;
    localparam int FRAME    = (VMAX - VMIN + 1) * REP;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [3:0]  in_data = '0;
    logic        clr_stats = 1'b0;
    logic        locked, err, frame_done;
    logic [3:0]  exp_data;
    logic [15:0] err_count;
    logic        locked2, err2, frame_done2;
    logic [3:0]  exp_data2;
    logic [1:0]  err_count2;

    always #5 clk = ~clk;

    pattern_repeat_checker #(.W(4), .VAL_MIN(VMIN), .VAL_MAX(VMAX), .REP(REP),
                             .LOCK_N(LOCK_N), .UNLOCK_N(UNLOCK_N), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clr_stats(clr_stats),
        .locked(locked), .err(err), .frame_done(frame_done), .exp_data(exp_data),
        .err_count(err_count)
    );

    pattern_repeat_checker #(.W(4), .VAL_MIN(VMIN), .VAL_MAX(VMAX), .REP(REP),
                             .LOCK_N(LOCK_N), .UNLOCK_N(UNLOCK_N), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clr_stats(clr_stats),
        .locked(locked2), .err(err2), .frame_done(frame_done2), .exp_data(exp_data2),
        .err_count(err_count2)
    );

    typedef struct {
        logic        locked;
        logic        err;
        logic        fd;
        logic [3:0]  ed;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
    } exp_t;

    typedef struct {
        logic       v;
        logic [3:0] d;
        logic       xl;
        logic       xe;
        logic [3:0] xd;
    } vec_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: position held as a linear index into one frame.
    int m_state, m_p, m_sync, m_miss, m_prev, m_cnt, m_cnt2;
    int g;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, want);
        end
    endtask

    task automatic model(input logic r, input logic v, input logic [3:0] d, input logic c);
        exp_t e;
        int di, ev;
        e.err = 1'b0;
        e.fd  = 1'b0;
        di = int'(d);
        if (r) begin
            m_state = 0; m_p = 0; m_prev = VMAX; m_sync = 0; m_miss = 0; m_cnt = 0; m_cnt2 = 0;
        end else begin
            if (v) begin
                ev = VMIN + m_p / REP;
                case (m_state)
                    0: if (di == VMIN && m_prev != VMIN) begin
                        m_p = 1 % FRAME; m_sync = 1; m_state = (LOCK_N == 1) ? 2 : 1;
                    end
                    1: if (di == ev) begin
                        m_p = (m_p + 1) % FRAME; m_sync++;
                        if (m_sync == LOCK_N) m_state = 2;
                    end else begin
                        m_state = 0; m_p = 0;
                    end
                    default: begin
                        e.fd = (m_p == FRAME - 1);
                        m_p = (m_p + 1) % FRAME;
                        if (di != ev) begin
                            e.err = 1'b1;
                            if (m_cnt < 65535) m_cnt++;
                            if (m_cnt2 < 3) m_cnt2++;
                            m_miss++;
                            if (m_miss == UNLOCK_N) begin
                                m_state = 0; m_p = 0; m_miss = 0;
                            end
                        end else begin
                            m_miss = 0;
                        end
                    end
                endcase
                m_prev = di;
            end
            if (c) begin
                m_cnt = 0; m_cnt2 = 0;
            end
        end
        e.locked = (m_state == 2);
        e.ed     = 4'(VMIN + m_p / REP);
        e.cnt    = 16'(m_cnt);
        e.cnt2   = 2'(m_cnt2);
        sbq.push_back(e);
    endtask

    task automatic step(input logic r, input logic v, input logic [3:0] d, input logic c);
        exp_t e;
        rst = r; in_valid = v; in_data = d; clr_stats = c;
        model(r, v, d, c);
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL sb_empty @%0t: got 0 entries expected 1", $time);
        end else begin
            e = sbq.pop_front();
            chk("locked", 32'(locked), 32'(e.locked));
            chk("err", 32'(err), 32'(e.err));
            chk("frame_done", 32'(frame_done), 32'(e.fd));
            chk("exp_data", 32'(exp_data), 32'(e.ed));
            chk("err_count", 32'(err_count), 32'(e.cnt));
            chk("err_count_w2", 32'(err_count2), 32'(e.cnt2));
        end
    endtask

    task automatic send();
        step(1'b0, 1'b1, 4'(VMIN + g / REP), 1'b0);
        g = (g + 1) % FRAME;
    endtask

    task automatic send_bad(input logic [3:0] d, input logic c);
        step(1'b0, 1'b1, d, c);
        g = (g + 1) % FRAME;
    endtask

    vec_t tbl[8];

    initial begin
        int last, npulse;
        logic [3:0] held;

        // Lock acquisition, expectations derived by hand.
        tbl[0] = '{1'b1, 4'd1, 1'b0, 1'b0, 4'd1};
        tbl[1] = '{1'b1, 4'd1, 1'b0, 1'b0, 4'd2};
        tbl[2] = '{1'b0, 4'd0, 1'b0, 1'b0, 4'd2};
        tbl[3] = '{1'b1, 4'd2, 1'b0, 1'b0, 4'd2};
        tbl[4] = '{1'b1, 4'd2, 1'b1, 1'b0, 4'd3};
        tbl[5] = '{1'b1, 4'd3, 1'b1, 1'b0, 4'd3};
        tbl[6] = '{1'b1, 4'd3, 1'b1, 1'b0, 4'd4};
        tbl[7] = '{1'b1, 4'd4, 1'b1, 1'b0, 4'd4};

        @(negedge clk);
        step(1'b1, 1'b0, 4'd0, 1'b0);
        step(1'b1, 1'b0, 4'd0, 1'b0);
        chk("reset_exp_data", 32'(exp_data), 32'(VMIN));
        for (int i = 0; i < 8; i++) begin
            step(1'b0, tbl[i].v, tbl[i].d, 1'b0);
            chk($sformatf("tbl%0d_locked", i), 32'(locked), 32'(tbl[i].xl));
            chk($sformatf("tbl%0d_err", i), 32'(err), 32'(tbl[i].xe));
            chk($sformatf("tbl%0d_exp_data", i), 32'(exp_data), 32'(tbl[i].xd));
        end
        g = 7;

        // Continuous locked stream: frame pulses every full frame.
        last = -1; npulse = 0;
        for (int i = 0; i < 40; i++) begin
            send();
            if (frame_done === 1'b1) begin
                if (last >= 0) chk("fd_spacing", 32'(i - last), 32'(FRAME));
                last = i;
                npulse++;
            end
        end
        chk("fd_pulses", 32'(npulse), 32'd2);

        // Single corrupted '5' replaced by '7'.
        for (int i = 0; i < FRAME && (VMIN + g / REP) != 5; i++) send();
        send_bad(4'd7, 1'b0);
        chk("t3_err", 32'(err), 32'd1);
        for (int i = 0; i < 10; i++) send();
        chk("t3_count", 32'(err_count), 32'd1);
        chk("t3_locked", 32'(locked), 32'd1);

        // Three consecutive mismatches force loss of lock, then relock.
        step(1'b0, 1'b0, 4'd0, 1'b1);
        for (int i = 0; i < 3; i++) send_bad(4'hF, 1'b0);
        chk("t4_count", 32'(err_count), 32'd3);
        chk("t4_locked", 32'(locked), 32'd0);
        g = 0;
        for (int i = 0; i < 3; i++) send();
        chk("t4_not_yet", 32'(locked), 32'd0);
        send();
        chk("t4_relock", 32'(locked), 32'd1);
        for (int i = 0; i < 5; i++) send();

        // Valid gap: nothing moves.
        held = exp_data;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 4'd0, 1'b0);
            chk("gap_exp_data", 32'(exp_data), 32'(held));
        end
        for (int i = 0; i < 10; i++) send();

        // Stream joined at the second '1': no alignment until a 1 follows a 9.
        step(1'b1, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'd1, 1'b0);
        g = 1;
        for (int i = 0; i < FRAME - 1; i++) send();
        chk("t5_hunt_locked", 32'(locked), 32'd0);
        chk("t5_hunt_exp", 32'(exp_data), 32'(VMIN));
        for (int i = 0; i < LOCK_N; i++) send();
        chk("t5_relock", 32'(locked), 32'd1);

        // Clear wins over a same-cycle increment.
        send_bad(4'hF, 1'b1);
        chk("t6_clr", 32'(err_count), 32'd0);
        send();

        // Isolated mismatches: narrow counter saturates.
        for (int i = 0; i < 5; i++) begin
            send_bad(4'hF, 1'b0);
            send();
            send();
        end
        chk("t6_sat_w2", 32'(err_count2), 32'd3);
        chk("t6_count", 32'(err_count), 32'd5);
        chk("t6_locked", 32'(locked), 32'd1);

        // Reset while locked.
        step(1'b1, 1'b1, 4'd1, 1'b0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_count", 32'(err_count), 32'd0);
        chk("rst_exp", 32'(exp_data), 32'(VMIN));
        step(1'b0, 1'b0, 4'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
